branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
//
// Purpose: direct-mapped table of ENTRIES entries. The IF stage looks up
// pc_i combinationally. The ID stage writes back resolved branches, and
// those writes become visible one cycle later. Mispredictions reported by
// ID are counted in a saturating statistics counter.
//
// Ports:
//   clk_i, rst_i       clock (rising edge), async active-high reset
//   pc_i               fetch address to look up
//   hit_o              valid entry with matching tag
//   pred_taken_o       hit and counter in WT/ST
//   pred_target_o      stored target if predicted taken, else pc_i+4
//   upd_valid_i        resolved branch this cycle
//   upd_pc_i           address of the resolved branch
//   upd_taken_i        actual outcome
//   upd_target_i       actual taken target
//   upd_mispredict_i   prediction was wrong (qualified by upd_valid_i)
//   inval_i            clear all valid bits
//   mispred_cnt_o      saturating misprediction count
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    output logic             hit_o,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_mispredict_i,
    input  logic             inval_i,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_cnt_d;

    assign lk_idx = pc_i[IDX_W+1:2];
    assign lk_tag = pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Bits outside index/tag do not participate in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_i[31:IDX_W+TAG_W+2], pc_i[1:0],
                              upd_pc_i[31:IDX_W+TAG_W+2], upd_pc_i[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not seen.
    assign hit_o         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o  = hit_o && cnt_q[lk_idx][1];
    assign pred_target_o = pred_taken_o ? target_q[lk_idx] : (pc_i + 32'd4);
    assign mispred_cnt_o = mispred_cnt_q;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        up_cnt_d = cnt_q[up_idx];
        if (upd_taken_i) begin
            if (cnt_q[up_idx] != ST) up_cnt_d = cnt_q[up_idx] + 2'd1;
        end else begin
            if (cnt_q[up_idx] != SNT) up_cnt_d = cnt_q[up_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= WNT;
            end
            mispred_cnt_q <= '0;
        end else begin
            // Invalidate suppresses any same-cycle table write so that no
            // entry can be left valid.
            if (inval_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (upd_valid_i) begin
                if (up_hit) begin
                    cnt_q[up_idx] <= up_cnt_d;
                    if (upd_taken_i) target_q[up_idx] <= upd_target_i;
                end else if (upd_taken_i) begin
                    valid_q[up_idx]  <= 1'b1;
                    tag_q[up_idx]    <= up_tag;
                    target_q[up_idx] <= upd_target_i;
                    cnt_q[up_idx]    <= WT;
                end
            end

            if (upd_valid_i && upd_mispredict_i &&
                (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

endmodule
